// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port, with an ack timeout.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on contention (default: data always wins).
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,

    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        busy,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;
    typedef enum logic {GNT_I, GNT_D} gnt_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    gnt_e        last_gnt_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        i_done_q, d_done_q, err_q;
    logic [31:0] i_rdata_q, d_rdata_q;

    logic        pick_d;
    logic        finish;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention, favour whoever did not win last time.
    assign pick_d = d_req && (!i_req || (last_gnt_q == GNT_I));
`else
    logic last_gnt_unused;
    assign last_gnt_unused = last_gnt_q;
    assign pick_d          = d_req;
`endif

    // Ack takes priority over timeout, so a late ack on the last cycle is a clean completion.
    assign finish = mem_ack || (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= GNT_I;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        mem_req_q <= 1'b1;
                        cnt_q     <= '0;
                        if (pick_d) begin
                            state_q     <= BUSY_D;
                            last_gnt_q  <= GNT_D;
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            state_q    <= BUSY_I;
                            last_gnt_q <= GNT_I;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= i_addr;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (finish) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= !mem_ack;
                        if (state_q == BUSY_I) begin
                            i_done_q  <= 1'b1;
                            i_rdata_q <= mem_ack ? mem_rdata : 32'h0;
                        end else begin
                            d_done_q <= 1'b1;
                            // Completed writes leave the last load word in place.
                            if (!mem_ack)
                                d_rdata_q <= 32'h0;
                            else if (!mem_we_q)
                                d_rdata_q <= mem_rdata;
                        end
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: fetch, load/store, timeout, reset abort and contention.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_done, d_done, err, busy;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_done(i_done), .i_rdata(i_rdata), .d_done(d_done), .d_rdata(d_rdata),
        .err(err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] gnt_q[$];
    int          n_chk = 0, n_fail = 0;
    logic [31:0] m_i_rd = '0, m_d_rd = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory responder: ack in BUSY cycle number ack_lat (0-based); 255 never acks.
    int          ack_lat = 0;
    logic [31:0] rd_word = '0;
    int          bcnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack   = (bcnt == ack_lat);
            mem_rdata = rd_word;
            bcnt++;
        end else begin
            mem_ack = 1'b0;
            bcnt    = 0;
        end
    end

    // Monitor: request length, payload hold, grant log, scoreboard pop on done.
    logic        prev_req = 1'b0, f_we = 1'b0, last_we = 1'b0;
    logic [31:0] f_addr = '0, f_wd = '0;
    int          req_len = 0, last_len = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_req = 1'b0;
            req_len  = 0;
        end else begin
            if (mem_req) begin
                if (!prev_req) begin
                    gnt_q.push_back(mem_addr);
                    f_addr  = mem_addr;
                    f_we    = mem_we;
                    f_wd    = mem_wdata;
                    req_len = 1;
                end else begin
                    req_len++;
                    chk("hold_addr", mem_addr, f_addr);
                    chk("hold_we", 32'(mem_we), 32'(f_we));
                    if (f_we) chk("hold_wdata", mem_wdata, f_wd);
                end
            end else if (prev_req) begin
                last_len = req_len;
                last_we  = f_we;
            end
            prev_req = mem_req;
            if (i_done || d_done) begin
                chk("one_done", 32'(i_done & d_done), 32'd0);
                chk("busy_resp", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_port", 32'(d_done), 32'(e.is_d));
                    chk("err", 32'(err), 32'(e.err));
                    chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                end
            end else if (err) begin
                chk("err_without_done", 32'(err), 32'd0);
            end
        end
    end

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (i_done || d_done) break;
            if (cyc >= max) begin
                chk("wait_done_bound", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    // One isolated transaction from a single requester, with latency and length checks.
    task automatic xact(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat, input logic [31:0] word,
                        input int exp_len);
        exp_t e;
        int   cyc;
        ack_lat = lat;
        rd_word = word;
        e.is_d  = is_d;
        e.err   = (lat >= TO);
        if (e.err)         e.rdata = 32'h0;
        else if (is_d && we) e.rdata = m_d_rd;
        else               e.rdata = word;
        if (is_d) m_d_rd = e.rdata; else m_i_rd = e.rdata;
        exp_q.push_back(e);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        wait_done(40, cyc);
        i_req = 1'b0;
        d_req = 1'b0;
        chk("turnaround", 32'(cyc), 32'(exp_len + 1));
        @(negedge clk);
        chk("back_idle", 32'(busy), 32'd0);
        chk("done_pulse_1", 32'(i_done | d_done), 32'd0);
        chk("req_len", 32'(last_len), 32'(exp_len));
        chk("req_we", 32'(last_we), 32'(is_d & we));
        chk("req_addr", f_addr, addr);
    endtask

    initial begin
        int cyc;
        exp_t e;
        logic [31:0] ea, ed;

        // Reset values, checked before any clock edge.
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        chk("rst_done_err", 32'(i_done | d_done | err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_req", 32'(mem_req | busy), 32'd0);

        xact(1'b0, 1'b0, 32'h100, 32'h0, 0, 32'h00500093, 1);     // single fetch
        xact(1'b1, 1'b0, 32'h3000, 32'h0, 1, 32'h12345678, 2);     // load
        xact(1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 3, 32'h55555555, 4); // store, ack on last cycle
        chk("store_keeps_drdata", d_rdata, 32'h12345678);
        xact(1'b1, 1'b0, 32'h3004, 32'h0, 255, 32'h77777777, 4);   // timeout
        chk("timeout_drdata", d_rdata, 32'h0);
        chk("ifetch_kept", i_rdata, 32'h00500093);

        // Reset during the second BUSY cycle.
        ack_lat = 255;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        @(negedge clk);
        chk("abort_busy1", 32'(mem_req), 32'd1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(i_done | d_done), 32'd0);
        chk("abort_irdata", i_rdata, 32'd0);
        d_req = 1'b0;
        m_i_rd = '0; m_d_rd = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_quiet", 32'(mem_req | busy), 32'd0);
        xact(1'b0, 1'b0, 32'h700, 32'h0, 2, 32'h0BADF00D, 3);

        // Contention: both requesters held high across four grants.
        gnt_q.delete();
        ack_lat = 0;
        rd_word = 32'hCAFE0001;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            e.is_d = (k % 2 == 0);
`else
            e.is_d = 1'b1;
`endif
            e.err   = 1'b0;
            e.rdata = 32'hCAFE0001;
            exp_q.push_back(e);
        end
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        for (int k = 0; k < 4; k++) begin
            wait_done(20, cyc);
            if (k == 3) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        chk("gnt_count", 32'(gnt_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < gnt_q.size(); k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ea = (k % 2 == 0) ? 32'h500 : 32'h400;
`else
            ea = 32'h500;
`endif
            ed = gnt_q[k];
            chk($sformatf("gnt_order_%0d", k), ed, ea);
        end
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
